// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer
// Generic inter-stage pipeline register. It forwards a payload and valid bit
// under the global stall vector, carries multi-cycle partial state back to
// the upstream stage while it is stalled, and squashes its contents on flush.
// Saturating bubble and hold counters are kept for performance analysis.
//
// Actions, one per cycle, highest priority first:
//   reset   : clear everything, including the counters
//   flush   : clear payload, valid and carry; counters keep their values
//   bubble  : up stalled, down running; insert a bubble and pass the carry through
//   advance : up running; load the upstream payload and zero the carry
//   hold    : up and down stalled; keep payload and valid, pass the carry through
// The pattern up=0, dn=1 is decoded as advance.
module pipe_stage_buffer #(
    parameter int DATA_WIDTH      = 103,
    parameter int CARRY_WIDTH     = 66,
    parameter int STALL_WIDTH     = 6,
    parameter int STAGE_INDEX     = 3,
    parameter bit CLEAR_ON_BUBBLE = 1'b1,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [STALL_WIDTH-1:0] i_stall,
    input  logic                   i_flush,
    input  logic                   i_valid,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic [CARRY_WIDTH-1:0] i_carry,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic [CARRY_WIDTH-1:0] o_carry,
    output logic [COUNT_WIDTH-1:0] o_bubble_count,
    output logic [COUNT_WIDTH-1:0] o_hold_count
);

    // The downstream stall bit must exist, so the top bit cannot be the upstream one.
    if (STAGE_INDEX < 0 || STAGE_INDEX > STALL_WIDTH - 2) begin : g_bad_stage_index
        $error("pipe_stage_buffer: STAGE_INDEX out of range 0..STALL_WIDTH-2");
    end

    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [CARRY_WIDTH-1:0] r_carry;
    logic [COUNT_WIDTH-1:0] r_bubble_count;
    logic [COUNT_WIDTH-1:0] r_hold_count;

    logic w_up;
    logic w_dn;
    logic w_bubble;
    logic w_hold;
    logic w_bubble_sat;
    logic w_hold_sat;
    logic w_unused_stall;

    assign w_up         = i_stall[STAGE_INDEX];
    assign w_dn         = i_stall[STAGE_INDEX+1];
    assign w_bubble     = w_up & ~w_dn;
    assign w_hold       = w_up & w_dn;
    assign w_bubble_sat = &r_bubble_count;
    assign w_hold_sat   = &r_hold_count;

    // Stall bits of other stages are irrelevant at this boundary.
    assign w_unused_stall = ^i_stall;

    // Valid and payload: cleared on reset/flush, dropped or held on stalls, loaded on advance.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_bubble) begin
            r_valid <= 1'b0;
            if (CLEAR_ON_BUBBLE) begin
                r_data <= '0;
            end
        end else if (!w_up) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    // Carry loops back to upstream only while upstream is stalled; advance and flush abort it.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_flush || !w_up) begin
            r_carry <= '0;
        end else begin
            r_carry <= i_carry;
        end
    end

    // Saturating performance counters; only reset clears them, flush leaves them alone.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_bubble_count <= '0;
            r_hold_count   <= '0;
        end else if (!i_flush) begin
            if (w_bubble && !w_bubble_sat) begin
                r_bubble_count <= r_bubble_count + 1'b1;
            end
            if (w_hold && !w_hold_sat) begin
                r_hold_count <= r_hold_count + 1'b1;
            end
        end
    end

    assign o_valid        = r_valid;
    assign o_data         = r_data;
    assign o_carry        = r_carry;
    assign o_bubble_count = r_bubble_count;
    assign o_hold_count   = r_hold_count;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: three instances (default, 2-bit counters,
// payload-holding bubbles) share stimulus; expectations go into a queue and
// a monitor compares them against the selected instance.
module tb_pipe_stage_buffer;

    localparam int DW = 103;
    localparam int CW = 66;

    typedef struct {
        string        name;
        int           sel;
        logic         v;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic [15:0]  bc;
        logic [15:0]  hc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_carry;

    logic          m_v, s_v, h_v;
    logic [DW-1:0] m_d, s_d, h_d;
    logic [CW-1:0] m_c, s_c, h_c;
    logic [15:0]   m_bc, m_hc, h_bc, h_hc;
    logic [1:0]    s_bc, s_hc;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   passed = 0;

    localparam logic [DW-1:0] D1  = {1'b1, 5'h05, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0};
    localparam logic [DW-1:0] D2  = {1'b1, 5'h1F, 32'hCAFEF00D, 1'b1, 32'h11112222, 32'h33334444};
    localparam logic [DW-1:0] D3  = {1'b0, 5'h0A, 32'h0BADC0DE, 1'b0, 32'h5, 32'h6};
    localparam logic [DW-1:0] DG  = 103'h12_3456_789A_BCDE_F012_3456_789A;
    localparam logic [DW-1:0] DAB = 103'hABC;
    localparam logic [CW-1:0] CG  = 66'h3_FFFF_0000_FFFF_0000;
    localparam logic [CW-1:0] C1  = {64'h1234, 2'b01};
    localparam logic [CW-1:0] C2  = {64'h5678, 2'b10};
    localparam logic [CW-1:0] C3  = {64'h9ABC, 2'b11};
    localparam logic [CW-1:0] C4  = {64'hA0A0, 2'b00};
    localparam logic [CW-1:0] C5  = {64'hB1B1, 2'b01};
    localparam logic [CW-1:0] C6  = {64'hC2C2, 2'b10};
    localparam logic [CW-1:0] C7  = {64'hD3D3, 2'b11};
    localparam logic [5:0] S_RUN = 6'b000000;
    localparam logic [5:0] S_BUB = 6'b001000;
    localparam logic [5:0] S_HLD = 6'b011000;
    localparam logic [5:0] S_ILL = 6'b010000;

    always #5 clk = ~clk;

    pipe_stage_buffer dut_main (
        .i_clock(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
        .i_valid(in_valid), .i_data(in_data), .i_carry(in_carry),
        .o_valid(m_v), .o_data(m_d), .o_carry(m_c),
        .o_bubble_count(m_bc), .o_hold_count(m_hc)
    );

    pipe_stage_buffer #(.COUNT_WIDTH(2)) dut_sat (
        .i_clock(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
        .i_valid(in_valid), .i_data(in_data), .i_carry(in_carry),
        .o_valid(s_v), .o_data(s_d), .o_carry(s_c),
        .o_bubble_count(s_bc), .o_hold_count(s_hc)
    );

    pipe_stage_buffer #(.CLEAR_ON_BUBBLE(1'b0)) dut_hold (
        .i_clock(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
        .i_valid(in_valid), .i_data(in_data), .i_carry(in_carry),
        .o_valid(h_v), .o_data(h_d), .o_carry(h_c),
        .o_bubble_count(h_bc), .o_hold_count(h_hc)
    );

    task automatic cmp(input string name, input string field,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s.%s: got %0h, expected %0h", name, field, act, exp);
        end
    endtask

    // Monitor: one registered output set per cycle, compared away from the active edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            logic          av;
            logic [DW-1:0] ad;
            logic [CW-1:0] ac;
            logic [15:0]   abc, ahc;
            e = q.pop_front();
            case (e.sel)
                1:       begin av = s_v; ad = s_d; ac = s_c; abc = {14'b0, s_bc}; ahc = {14'b0, s_hc}; end
                2:       begin av = h_v; ad = h_d; ac = h_c; abc = h_bc; ahc = h_hc; end
                default: begin av = m_v; ad = m_d; ac = m_c; abc = m_bc; ahc = m_hc; end
            endcase
            cmp(e.name, "valid",  {{(DW-1){1'b0}}, av}, {{(DW-1){1'b0}}, e.v});
            cmp(e.name, "data",   ad, e.d);
            cmp(e.name, "carry",  {{(DW-CW){1'b0}}, ac}, {{(DW-CW){1'b0}}, e.c});
            cmp(e.name, "bubble", {{(DW-16){1'b0}}, abc}, {{(DW-16){1'b0}}, e.bc});
            cmp(e.name, "hold",   {{(DW-16){1'b0}}, ahc}, {{(DW-16){1'b0}}, e.hc});
        end
    end

    // The stall controller never produces up=0/dn=1; note it without failing.
    always @(posedge clk) begin
        if (!rst && stall[3] == 1'b0 && stall[4] == 1'b1) begin
            $display("WARNING: stall pattern up=0 dn=1 seen, treated as advance");
        end
    end

    task automatic step(input logic r, input logic f, input logic [5:0] st,
                        input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input string name, input int sel,
                        input logic ev, input logic [DW-1:0] ed, input logic [CW-1:0] ec,
                        input logic [15:0] ebc, input logic [15:0] ehc);
        exp_t x;
        @(negedge clk);
        rst = r; flush = f; stall = st; in_valid = v; in_data = d; in_carry = c;
        @(posedge clk);
        x.name = name; x.sel = sel; x.v = ev; x.d = ed; x.c = ec; x.bc = ebc; x.hc = ehc;
        q.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b1; stall = S_HLD; in_valid = 1'b1; in_data = DG; in_carry = CG;

        // Reset with garbage inputs, then with a live stall pattern
        step(1, 1, S_BUB, 1, DG, CG, "reset0", 0, 0, '0, '0, 0, 0);
        step(1, 0, S_RUN, 1, DG, CG, "reset1", 0, 0, '0, '0, 0, 0);
        step(1, 0, S_HLD, 1, DG, CG, "reset_stall", 0, 0, '0, '0, 0, 0);

        // Advance
        step(0, 0, S_RUN, 1, D1, CG, "advance", 0, 1, D1, '0, 0, 0);

        // Multi-cycle bubble and release
        step(0, 0, S_BUB, 1, DG, C1, "bubble1", 0, 0, '0, C1, 1, 0);
        step(0, 0, S_BUB, 1, DG, C2, "bubble2", 0, 0, '0, C2, 2, 0);
        step(0, 0, S_BUB, 1, DG, C3, "bubble3", 0, 0, '0, C3, 3, 0);
        step(0, 0, S_RUN, 1, D2, C3, "release", 0, 1, D2, '0, 3, 0);

        // Hold a valid payload
        step(0, 0, S_HLD, 0, DG, C4, "hold1", 0, 1, D2, C4, 3, 1);
        step(0, 0, S_HLD, 0, DG, C5, "hold2", 0, 1, D2, C5, 3, 2);
        step(0, 0, S_HLD, 0, DG, C6, "hold3", 0, 1, D2, C6, 3, 3);
        step(0, 0, S_HLD, 1, D1, C7, "hold4", 0, 1, D2, C7, 3, 4);

        // Flush beats a bubble
        step(0, 1, S_BUB, 1, DG, C7, "flush_bub", 0, 0, '0, '0, 3, 4);

        // up=0 dn=1 behaves as advance
        step(0, 0, S_ILL, 1, D3, C5, "illegal_adv", 0, 1, D3, '0, 3, 4);

        // Flush and reset together: reset wins, counters clear
        step(1, 1, S_HLD, 1, DG, CG, "flush_reset", 0, 0, '0, '0, 0, 0);

        // Reset in the middle of a bubble run; next action decided by inputs alone
        step(0, 0, S_BUB, 1, DG, C1, "mid_bub1", 0, 0, '0, C1, 1, 0);
        step(0, 0, S_BUB, 1, DG, C2, "mid_bub2", 0, 0, '0, C2, 2, 0);
        step(1, 0, S_BUB, 1, DG, C3, "mid_reset", 0, 0, '0, '0, 0, 0);
        step(0, 0, S_HLD, 1, DG, C4, "post_reset_hold", 0, 0, '0, C4, 0, 1);

        // Saturation with a 2-bit bubble counter
        step(1, 0, S_RUN, 0, '0, '0, "sat_reset", 1, 0, '0, '0, 0, 0);
        step(0, 0, S_BUB, 1, DG, C1, "sat1", 1, 0, '0, C1, 1, 0);
        step(0, 0, S_BUB, 1, DG, C2, "sat2", 1, 0, '0, C2, 2, 0);
        step(0, 0, S_BUB, 1, DG, C3, "sat3", 1, 0, '0, C3, 3, 0);
        step(0, 0, S_BUB, 1, DG, C4, "sat4", 1, 0, '0, C4, 3, 0);
        step(0, 0, S_BUB, 1, DG, C5, "sat5", 1, 0, '0, C5, 3, 0);

        // Payload kept across a bubble when clearing is disabled
        step(1, 0, S_RUN, 0, '0, '0, "cob_reset", 2, 0, '0, '0, 0, 0);
        step(0, 0, S_RUN, 1, DAB, CG, "cob_load", 2, 1, DAB, '0, 0, 0);
        step(0, 0, S_BUB, 1, DG, C6, "cob_bubble", 2, 0, DAB, C6, 1, 0);

        @(negedge clk);
        rst = 1'b1; flush = 1'b0; stall = S_RUN; in_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        #2;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised inter-stage pipeline register for the five-stage CPU pipeline. It replaces the hand-written per-stage buffers: it forwards a generic payload with a valid bit and applies the common stall-vector rules. It also carries multi-cycle partial state (e.g. div/madd accumulators) across stalled cycles, supports a flush for exception/branch squash, and keeps saturating bubble/hold counters for performance analysis. Instantiated between EX and MEM first, then reused for the other stage boundaries.

## Interface
- DATA_WIDTH, 103: payload width. The EX/MEM packing is {write_enable, write_addr[4:0], write_data[31:0], write_hilo_enable, hi[31:0], lo[31:0]}.
- CARRY_WIDTH, 66: multi-cycle carry width, packed as {result[63:0], cycle[1:0]}.
- STALL_WIDTH, 6: width of the global stall vector.
- STAGE_INDEX, 3: stall bit of the upstream stage. Legal range is 0..STALL_WIDTH-2; any other value is an elaboration error.
- CLEAR_ON_BUBBLE, 1: selects the payload on a bubble.
  - 1: payload is zeroed.
  - 0: payload holds its previous value and only out_valid drops.
- COUNT_WIDTH, 16: width of each performance counter.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  STALL_WIDTH  global stall vector; bit i set means stage i is stalled.
- flush  in  1  squash the contents of this boundary.
- in_valid  in  1  upstream instruction is valid.
- in_data  in  DATA_WIDTH  upstream payload.
- in_carry  in  CARRY_WIDTH  upstream multi-cycle partial state for the current cycle.
- out_valid  out  1  registered valid to the downstream stage.
- out_data  out  DATA_WIDTH  registered payload.
- out_carry  out  CARRY_WIDTH  registered partial state, fed back to upstream.
- bubble_count  out  COUNT_WIDTH  saturating count of bubbles inserted.
- hold_count  out  COUNT_WIDTH  saturating count of hold cycles.

## Operation
- Definitions:
  - up = stall[STAGE_INDEX]
  - dn = stall[STAGE_INDEX+1]
- One action per cycle. Priority is reset > flush > bubble > advance > hold.
- RESET (reset=1):
  - out_valid=0, out_data=0, out_carry=0.
  - bubble_count=0, hold_count=0.
- FLUSH (flush=1, reset=0):
  - out_valid=0, out_data=0, out_carry=0. Clearing out_carry aborts any in-flight multi-cycle operation.
  - Counters are unchanged.
  - A flush overrides all stall bits.
- BUBBLE (up=1, dn=0):
  - out_valid=0.
  - out_data=0 if CLEAR_ON_BUBBLE, otherwise held.
  - out_carry=in_carry.
  - bubble_count+1, saturating at all-ones.
- ADVANCE (up=0):
  - out_valid=in_valid, out_data=in_data, out_carry=0.
  - Counters are unchanged.
- HOLD (up=1, dn=1):
  - out_valid and out_data are held.
  - out_carry=in_carry.
  - hold_count+1, saturating.
- The state up=0, dn=1 is treated as ADVANCE. The stall controller never drives it; the bench must flag it with a warning only.
- Counters saturate at 2^COUNT_WIDTH-1 and never wrap. Only reset clears them.
- No combinational path from any input to any output.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- out_carry captured at edge N is what upstream reads during cycle N+1. This is the one-cycle feedback loop for multi-cycle ops.
- Reset mid-operation (during a run of BUBBLE or HOLD cycles):
  - All outputs are cleared at that edge.
  - The first action after reset deasserts is decided purely by the stall and flush inputs at the next edge.
- flush and reset asserted together: reset behaviour applies. Values are identical except the counters, which reset clears.
- Bubble then advance: the carry is zero on the edge of the advance. The upstream op must have produced its final result by then.

## Test plan
- Reset: drive garbage on all inputs with reset=1 for 2 cycles. Required: all outputs are 0, and stay 0 one cycle after any non-reset stall pattern is applied with reset=1.
- Advance: stall=0, in_valid=1, in_data=0x1_05_DEADBEEF_0_00000000_00000000. Required: identical out_data with out_valid=1 after 1 edge, and out_carry=0.
- Multi-cycle bubble:
  - Stimulus: stall=6'b001000 for 3 cycles with in_carry={64'h1234, 2'b01}, then {64'h5678, 2'b10}, then {64'h9ABC, 2'b11}; then stall=0.
  - Required: out_valid=0 and out_data=0 for the three stalled cycles; out_carry tracks each value one edge later; bubble_count=3; out_carry=0 after the release edge.
- Hold: load a valid payload, then stall=6'b011000 for 4 cycles. Required: out_data and out_valid are unchanged, hold_count=4, out_carry follows in_carry.
- Flush priority: flush=1 together with stall=6'b001000 and in_carry nonzero. Required: out_valid=0, out_data=0, out_carry=0, bubble_count unchanged.
- Saturation and mode:
  - With COUNT_WIDTH=2, run 5 bubbles. Required: bubble_count=3.
  - With CLEAR_ON_BUBBLE=0, a bubble after payload 0xABC keeps out_data=0xABC with out_valid=0.
